sum_latch_uart_tx: RTL
======================

# sum_latch_uart_tx

Parametrised operand-latch / arithmetic / UART transmit engine. Captures two DATA_W-bit operands from a shared input bus on operand strobes, forms their sum or difference at DATA_W+1 bits, and serialises the result as one or more 8-bit UART frames, LSB byte first. It is the successor of the 4-bit sum-and-send core. New over that core: configurable width and baud, subtract mode, optional even parity, multi-byte results, a manual resend strobe and a one-deep pending-transmit buffer. It sits between the pad-level wrapper and the TX pin.

## Interface
Parameters:
- DATA_W, 4: operand width, 1..24.
- CLKS_PER_BIT, 16: clk cycles per UART bit, at least 2.
- PARITY_EN, 0: when 1, an even-parity bit follows the data bits.

Ports:
- clk, input, 1: sole clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- data_in, input, DATA_W: operand bus.
- save_a, input, 1: active-high strobe. Its rising edge latches data_in into A.
- save_b, input, 1: active-high strobe. Its rising edge latches data_in into B and requests a transmit.
- send, input, 1: active-high strobe. Its rising edge requests a transmit of the current result without changing A or B.
- op_sub, input, 1: 0 selects A+B, 1 selects A−B. Sampled when the transmit snapshot is taken.
- result, output, DATA_W+1: registered live result of the current A and B under the current op_sub.
- uart_txd, output, 1: serial line; idles high.
- uart_tx_busy, output, 1: high while a transmission is in progress.

## Operation
- Edge detection:
  - Each strobe is registered; an edge is a current sample of 1 with a previous sample of 0.
  - A level held high produces one event only.
- Operands:
  - A and B are DATA_W-bit registers that update on their edge at any time, including while busy.
  - If save_a and save_b have an edge in the same cycle, both latch data_in.
- Arithmetic: the result is computed modulo 2^(DATA_W+1).
  - Add: bit DATA_W is the carry.
  - Sub: the result is the two's-complement difference.
  - The result register updates one cycle after A, B or op_sub change.
- Transmit word:
  - NBYTES = ceil((DATA_W+1)/8).
  - The snapshot is zero-extended to NBYTES×8 bits and sent byte 0 first.
  - Each byte is sent LSB first.
- Frame format:
  - 1 start bit (0), 8 data bits, a parity bit if PARITY_EN (XOR of the 8 data bits), 1 stop bit (1).
  - The bytes of one word are sent back-to-back: the next start bit follows the stop bit immediately.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a request, or on a pending flag. On this transition the snapshot (A op B) is taken into the shift register and the byte index is cleared.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY (or STOP when PARITY_EN=0) after the 8th bit period.
  - PARITY → STOP after one bit period.
  - STOP → START when bytes remain, incrementing the byte index.
  - STOP → IDLE after the last byte.
- Pending buffer:
  - A request that arrives while not in IDLE sets a pending flag. Further requests while the flag is set are absorbed.
  - The flag is cleared when IDLE → START.
  - A pending transmit snapshots the operands as they are at its start, not at request time.
- Reset:
  - Outputs: uart_txd=1, uart_tx_busy=0, result=0.
  - Internal state: A=B=0, pending=0, FSM=IDLE, all counters=0, edge-detect history=0.
  - Reset in mid-frame aborts the frame immediately; the line returns high on the next cycle.

## Timing
- A save_b edge sampled at edge k:
  - B updates at edge k.
  - The FSM enters START at edge k+1, using the new B.
  - uart_txd falls after edge k+1.
- uart_tx_busy rises at the same edge as the START entry.
- uart_tx_busy falls at the edge where STOP of the last byte completes. The line stays high from then on.
- Bit period: exactly CLKS_PER_BIT cycles per bit, with no jitter.
- Word length: NBYTES×(10+PARITY_EN)×CLKS_PER_BIT cycles.
- A pending transmit starts at the edge following the return to IDLE, so there is one idle-high cycle between words.
- A request in the same cycle as STOP→IDLE sets pending; it is not lost.

## Test plan
- Add: DATA_W=4, CLKS_PER_BIT=4, A=9, B=8, op_sub=0, pulse save_b → result=0x11; one frame carrying 0x11; busy high for 40 cycles.
- Sub: A=3, B=5, op_sub=1 → result=5'b11110; transmitted byte 0x1E.
- Multi-byte: DATA_W=12, A=0xFFF, B=0x001 → result=0x1000; bytes 0x00 then 0x10, back-to-back; busy for 80 cycles.
- Pending: send pulsed twice mid-frame, A changed to 2 before the first frame ends → exactly one extra frame follows, carrying the new sum, after one idle cycle.
- Parity: PARITY_EN=1, byte 0x07 → parity bit 1; byte 0x03 → parity bit 0; frame length 11 bit periods.
- Reset in the DATA state → next cycle uart_txd=1, busy=0, result=0. A subsequent save_b transmits 0+data_in.

Source files
------------

// File: rtl/sum_latch_uart_tx.sv
// Latches two operands on strobe edges, adds or subtracts them, and sends the result as UART bytes, LSB byte first.
// Output latency: a save_b edge starts a frame one cycle later; a request made while busy is held in a one-deep pending flag.
module sum_latch_uart_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              save_a,
    input  logic              save_b,
    input  logic              send,
    input  logic              op_sub,
    output logic [DATA_W:0]   result,
    output logic              uart_txd,
    output logic              uart_tx_busy
);

    localparam int RW     = DATA_W + 1;
    localparam int NBYTES = (RW + 7) / 8;
    localparam int SW     = NBYTES * 8;
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0] BYTE_LAST = BIW'(NBYTES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic              save_a_q, save_b_q, send_q;
    logic              req_q, pend_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [RW-1:0]     res_q;
    logic [RW-1:0]     live_d;
    logic [SW-1:0]     snap_d;
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        bit_q;
    logic [BIW-1:0]    byte_q;
    logic [SW-1:0]     sh_q;
    logic              par_q, txd_q, busy_q;
    logic              a_edge, b_edge, s_edge, bit_end, go;

    assign a_edge  = save_a & ~save_a_q;
    assign b_edge  = save_b & ~save_b_q;
    assign s_edge  = send & ~send_q;
    assign live_d  = op_sub ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
    assign snap_d  = SW'(live_d);
    assign bit_end = (cnt_q == CNT_LAST);
    assign go      = req_q | pend_q;

    // req_q delays the request by one cycle so the snapshot sees the freshly latched B
    always_ff @(posedge clk) begin
        if (reset) begin
            save_a_q <= 1'b0;
            save_b_q <= 1'b0;
            send_q   <= 1'b0;
            req_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            save_a_q <= save_a;
            save_b_q <= save_b;
            send_q   <= send;
            req_q    <= b_edge | s_edge;
            res_q    <= live_d;
            if (a_edge) a_q <= data_in;
            if (b_edge) b_q <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
            if (state_q != IDLE && req_q) pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q <= START;
                        pend_q  <= 1'b0;
                        sh_q    <= snap_d;
                        byte_q  <= '0;
                        par_q   <= ^snap_d[7:0];
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        txd_q   <= sh_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        sh_q <= sh_q >> 1;
                        if (bit_q == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            txd_q <= sh_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (byte_q == BYTE_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // after eight shifts the next byte sits in the low bits
                            state_q <= START;
                            byte_q  <= byte_q + 1'b1;
                            par_q   <= ^sh_q[7:0];
                            txd_q   <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result       = res_q;
    assign uart_txd     = txd_q;
    assign uart_tx_busy = busy_q;

endmodule
